// File: rtl/boutons_pkg.sv
// Shared constants for the board push-button front end.
// Polarity of the KEY pins and default debounce window for a 50 MHz clock.
package boutons_pkg;

   localparam int BOUTONS_CLK_HZ           = 50_000_000;
   localparam int BOUTONS_DEBOUNCE_DEFAULT = 500000;

   // The board KEY pins read 0 while the button is held down.
   localparam bit BOUTONS_KEY_ACTIVE_LOW   = 1'b1;

   function automatic int boutons_cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/boutons_debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter and edge pulses.
// The input is already in pressed-polarity (1 = pressed).
module debounce_channel
   import boutons_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = BOUTONS_DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic level_in,
   output logic state,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int                CNT_W   = boutons_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   // The counter only runs while sync2 disagrees with the accepted level, so any
   // return to the accepted level (glitch or bounce) restarts the window from zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1         <= 1'b0;
         sync2         <= 1'b0;
         stable        <= 1'b0;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync1         <= level_in;
         sync2         <= sync1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable        <= sync2;
            cnt           <= '0;
            press_pulse   <= sync2;
            release_pulse <= ~sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign state = stable;

endmodule

// File: rtl/boutons_debounce.sv
// Debounced push-button front end feeding the button PIO in_port.
// Normalises pin polarity, then runs one independent debouncer per key.
module boutons_debounce
   import boutons_pkg::*;
#(
   parameter int N               = 2,
   parameter int DEBOUNCE_CYCLES = BOUTONS_DEBOUNCE_DEFAULT,
   parameter bit ACTIVE_LOW      = BOUTONS_KEY_ACTIVE_LOW
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] key_in,
   output logic [N-1:0] btn_state,
   output logic [N-1:0] press_pulse,
   output logic [N-1:0] release_pulse
);

   logic [N-1:0] pressed_level;

   assign pressed_level = key_in ^ {N{ACTIVE_LOW}};

   for (genvar i = 0; i < N; i++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clk          (clk),
         .reset        (reset),
         .level_in     (pressed_level[i]),
         .state        (btn_state[i]),
         .press_pulse  (press_pulse[i]),
         .release_pulse(release_pulse[i])
      );
   end

endmodule

// File: tb/tb_boutons_debounce.sv
// Directed self-checking bench for boutons_debounce with an 8-cycle window.
// Expected levels and pulse timings are hand-derived from the edge numbering.
module tb_boutons_debounce;

   localparam int N  = 2;
   localparam int DC = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] key_in;
   logic [N-1:0] btn_state;
   logic [N-1:0] press_pulse;
   logic [N-1:0] release_pulse;

   int assertCount = 0;
   int failCount   = 0;
   int pressCount [N];
   int releaseCount [N];
   int overlapCount = 0;

   boutons_debounce #(
      .N              (N),
      .DEBOUNCE_CYCLES(DC),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_in       (key_in),
      .btn_state    (btn_state),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic clearCounts();
      for (int i = 0; i < N; i++) begin
         pressCount[i]   = 0;
         releaseCount[i] = 0;
      end
   endtask

   // Hold key_in for a number of clock edges, sampling outputs 1 time unit after each edge.
   task automatic applyStimulus(input logic [N-1:0] keys, input int cycles);
      key_in = keys;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (press_pulse[i])   pressCount[i]++;
            if (release_pulse[i]) releaseCount[i]++;
            if (press_pulse[i] && release_pulse[i]) overlapCount++;
         end
      end
   endtask

   initial begin
      reset  = 1'b1;
      key_in = 2'b11;
      clearCounts();
      applyStimulus(2'b11, 3);
      checkOutput("reset_btn_state", 32'(btn_state), 32'h0);
      checkOutput("reset_press", 32'(press_pulse), 32'h0);
      checkOutput("reset_release", 32'(release_pulse), 32'h0);
      reset = 1'b0;
      applyStimulus(2'b11, 12);
      checkOutput("idle_btn_state", 32'(btn_state), 32'h0);

      // Clean press on key 0
      clearCounts();
      applyStimulus(2'b10, DC + 1);
      checkOutput("press_edge9_state", 32'(btn_state), 32'h0);
      applyStimulus(2'b10, 1);
      checkOutput("press_edge10_state", 32'(btn_state), 32'h1);
      checkOutput("press_edge10_pulse", 32'(press_pulse), 32'h1);
      applyStimulus(2'b10, 1);
      checkOutput("press_pulse_width", 32'(press_pulse), 32'h0);
      checkOutput("press_count", 32'(pressCount[0]), 32'd1);

      // Release of key 0
      clearCounts();
      applyStimulus(2'b11, DC + 1);
      checkOutput("release_edge9_state", 32'(btn_state), 32'h1);
      applyStimulus(2'b11, 1);
      checkOutput("release_edge10_state", 32'(btn_state), 32'h0);
      checkOutput("release_edge10_pulse", 32'(release_pulse), 32'h1);
      checkOutput("release_no_press", 32'(press_pulse), 32'h0);
      applyStimulus(2'b11, 4);
      checkOutput("release_count", 32'(releaseCount[0]), 32'd1);
      checkOutput("release_press_count", 32'(pressCount[0]), 32'd0);

      // Glitches of 5 and 7 cycles are rejected
      clearCounts();
      applyStimulus(2'b10, 5);
      applyStimulus(2'b11, 12);
      checkOutput("glitch5_state", 32'(btn_state), 32'h0);
      checkOutput("glitch5_pulses", 32'(pressCount[0]), 32'd0);
      applyStimulus(2'b10, DC - 1);
      applyStimulus(2'b11, 12);
      checkOutput("glitch7_state", 32'(btn_state), 32'h0);
      checkOutput("glitch7_pulses", 32'(pressCount[0]), 32'd0);

      // An 8-cycle low is accepted at edge 10, then the release follows 8 edges later
      applyStimulus(2'b10, DC);
      applyStimulus(2'b11, 2);
      checkOutput("hold8_state", 32'(btn_state), 32'h1);
      checkOutput("hold8_press", 32'(pressCount[0]), 32'd1);
      applyStimulus(2'b11, 7);
      checkOutput("hold8_before_release", 32'(btn_state), 32'h1);
      applyStimulus(2'b11, 1);
      checkOutput("hold8_released", 32'(btn_state), 32'h0);
      checkOutput("hold8_release_count", 32'(releaseCount[0]), 32'd1);
      applyStimulus(2'b11, 4);

      // Bounce: count restarts each time the level returns
      clearCounts();
      applyStimulus(2'b10, 3);
      applyStimulus(2'b11, 1);
      applyStimulus(2'b10, 3);
      applyStimulus(2'b11, 1);
      applyStimulus(2'b10, DC + 1);
      checkOutput("bounce_edge9_state", 32'(btn_state), 32'h0);
      applyStimulus(2'b10, 1);
      checkOutput("bounce_edge10_state", 32'(btn_state), 32'h1);
      checkOutput("bounce_edge10_pulse", 32'(press_pulse), 32'h1);
      applyStimulus(2'b10, 3);
      checkOutput("bounce_press_count", 32'(pressCount[0]), 32'd1);

      // Return to idle, then press both keys together
      applyStimulus(2'b11, DC + 4);
      checkOutput("idle_again", 32'(btn_state), 32'h0);
      clearCounts();
      applyStimulus(2'b00, DC + 1);
      checkOutput("both_edge9_state", 32'(btn_state), 32'h0);
      applyStimulus(2'b00, 1);
      checkOutput("both_edge10_pulse", 32'(press_pulse), 32'h3);
      checkOutput("both_edge10_state", 32'(btn_state), 32'h3);

      // Reset mid-count while key 1 stays held
      applyStimulus(2'b01, 5);
      reset = 1'b1;
      applyStimulus(2'b01, 1);
      checkOutput("midreset_state", 32'(btn_state), 32'h0);
      checkOutput("midreset_press", 32'(press_pulse), 32'h0);
      checkOutput("midreset_release", 32'(release_pulse), 32'h0);
      reset = 1'b0;
      clearCounts();
      applyStimulus(2'b01, DC + 1);
      checkOutput("held_edge9_state", 32'(btn_state), 32'h0);
      checkOutput("held_edge9_press", 32'(pressCount[1]), 32'd0);
      applyStimulus(2'b01, 1);
      checkOutput("held_edge10_pulse", 32'(press_pulse), 32'h2);
      checkOutput("held_edge10_state", 32'(btn_state), 32'h2);
      applyStimulus(2'b01, 3);
      checkOutput("held_ch0_quiet", 32'(pressCount[0] + releaseCount[0]), 32'd0);

      checkOutput("no_press_release_overlap", 32'(overlapCount), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
